sram_like_arbiter_nx1: RTL and testbench

- Parametrised N-to-1 sram-like arbiter for the data side between the cache/uncached split and cpu_axi_interface.
- Generalises the fixed 2-way cached/uncached merge to N masters (e.g. D-cache, uncached path, write buffer), with in-order outstanding-transaction tracking.
- Each data_ok/rdata is returned to the master that issued the matching request.

---
 rtl/sram_like_arbiter_nx1.sv | 173 +++++++++++++++++
 tb/tb_sram_like_arbiter_nx1.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter_nx1.sv
// N-to-1 sram-like request arbiter with in-order ID tracking for data returns.
// SRAM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority (master 0 highest).
module sram_like_arbiter_nx1 #(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTERS-1:0]             m_req,
  input  logic [N_MASTERS-1:0]             m_wr,
  input  logic [2*N_MASTERS-1:0]           m_size,
  input  logic [ADDR_W*N_MASTERS-1:0]      m_addr,
  input  logic [DATA_W*N_MASTERS-1:0]      m_wdata,
  output logic [N_MASTERS-1:0]             m_addr_ok,
  output logic [N_MASTERS-1:0]             m_data_ok,
  output logic [DATA_W-1:0]                m_rdata,
  output logic                             s_req,
  output logic                             s_wr,
  output logic [1:0]                       s_size,
  output logic [ADDR_W-1:0]                s_addr,
  output logic [DATA_W-1:0]                s_wdata,
  input  logic                             s_addr_ok,
  input  logic                             s_data_ok,
  input  logic [DATA_W-1:0]                s_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic [ID_W-1:0] winner, grant;
  logic            found;
  logic            any_req, full, accept, pop;

  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [ADDR_W-1:0] addr_arr  [N_MASTERS];
  logic [DATA_W-1:0] wdata_arr [N_MASTERS];
  logic [1:0]        size_arr  [N_MASTERS];

  always_comb begin
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = m_wdata[i*DATA_W +: DATA_W];
      size_arr[i]  = m_size[2*i +: 2];
    end
  end

`ifdef SRAM_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      idx = ID_W'((32'(rr_ptr_q) + i) % N_MASTERS);
      if (!found && m_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (32'(grant) == N_MASTERS - 1) ? '0 : grant + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (!found && m_req[ID_W'(i)]) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
  end
`endif

  assign any_req = |m_req;
  assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign grant   = (state_q == S_LOCKED) ? lock_id_q : winner;
  // A full FIFO blocks the request outright; a same-cycle pop only frees space next cycle.
  assign s_req   = ((state_q == S_LOCKED) ? m_req[lock_id_q] : any_req) & ~full & ~rst;
  assign accept  = s_req & s_addr_ok;
  assign pop     = s_data_ok & (count_q != '0) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      S_IDLE: begin
        if (any_req && !full && !s_addr_ok) begin
          state_d   = S_LOCKED;
          lock_id_d = winner;
        end
      end
      S_LOCKED: begin
        if (!m_req[lock_id_q] || accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    if (accept) m_addr_ok[grant] = 1'b1;
    if (pop)    m_data_ok[fifo_q[rd_ptr_q]] = 1'b1;
    s_wr    = rst ? 1'b0 : m_wr[grant];
    s_size  = rst ? '0 : size_arr[grant];
    s_addr  = rst ? '0 : addr_arr[grant];
    s_wdata = rst ? '0 : wdata_arr[grant];
    m_rdata = rst ? '0 : s_rdata;
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_q[wr_ptr_q] <= grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (s_data_ok && count_q == '0) err_q <= 1'b1;
    end
  end

  assign outstanding = rst ? '0 : count_q;
  assign err         = err_q & ~rst;

endmodule

// File: tb/tb_sram_like_arbiter_nx1.sv
// Directed bench for sram_like_arbiter_nx1 (N=2, depth 4); expectations follow the build's arbitration mode.
module tb_sram_like_arbiter_nx1;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_wr;
  logic [2*N-1:0]  m_size;
  logic [AW*N-1:0] m_addr;
  logic [DW*N-1:0] m_wdata;
  logic [N-1:0]    m_addr_ok, m_data_ok;
  logic [DW-1:0]   m_rdata;
  logic            s_req, s_wr;
  logic [1:0]      s_size;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_addr_ok, s_data_ok;
  logic [DW-1:0]   s_rdata;
  logic [2:0]      outstanding;
  logic            err;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned exp_g [6];
  int          acc, ret;

  always #5 clk = ~clk;

  sram_like_arbiter_nx1 #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int unsigned g);
    return 64'd1 << g;
  endfunction

  // Drive one cycle's inputs at the falling edge; checks follow 2 ns later.
  task automatic cyc(input logic [N-1:0] req, input logic aok, input logic dok, input logic [DW-1:0] rd);
    @(negedge clk);
    m_req = req; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; m_req = '0; m_wr = '0; m_size = {2'b01, 2'b10};
    m_addr  = {32'h1FC0_0010, 32'h0000_1000};
    m_wdata = {32'h5555_0001, 32'hAAAA_0000};
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

    cyc(2'b01, 1'b1, 1'b1, 32'hFF);
    chk("rst_sreq", 64'(s_req), 64'd0);
    chk("rst_aok",  64'(m_addr_ok), 64'd0);
    chk("rst_dok",  64'(m_data_ok), 64'd0);
    chk("rst_out",  64'(outstanding), 64'd0);
    chk("rst_err",  64'(err), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Both masters request every cycle; downstream returns 2 cycles after accept.
`ifdef SRAM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0, 0, 0};
`endif
    for (int c = 0; c < 9; c++) begin
      cyc((c < 6) ? 2'b11 : 2'b00, 1'b1, (c >= 2 && c < 8), 32'hD0 + c);
      acc = (c < 6) ? c : 6;
      ret = ((c < 8) ? c : 8) - 2;
      if (ret < 0) ret = 0;
      chk("t1_aok", 64'(m_addr_ok), (c < 6) ? oh(exp_g[c]) : 64'd0);
      chk("t1_dok", 64'(m_data_ok), (c >= 2 && c < 8) ? oh(exp_g[c-2]) : 64'd0);
      chk("t1_out", 64'(outstanding), 64'(acc - ret));
      if (c < 6) chk("t1_addr", 64'(s_addr), (exp_g[c] == 1) ? 64'h1FC0_0010 : 64'h1000);
      if (c >= 2 && c < 8) chk("t1_rdata", 64'(m_rdata), 64'(32'hD0 + c));
    end

    // Reads from masters 0,1,0 returning A,B,C.
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("t5_aok0", 64'(m_addr_ok), 64'h1);
    chk("t5_addr0", 64'(s_addr), 64'h1000);
    chk("t5_size0", 64'(s_size), 64'h2);
    cyc(2'b10, 1'b1, 1'b0, 32'h0);
    chk("t5_aok1", 64'(m_addr_ok), 64'h2);
    chk("t5_addr1", 64'(s_addr), 64'h1FC0_0010);
    chk("t5_size1", 64'(s_size), 64'h1);
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("t5_aok2", 64'(m_addr_ok), 64'h1);
    cyc(2'b00, 1'b0, 1'b1, 32'hA);
    chk("t5_out", 64'(outstanding), 64'd3);
    chk("t5_dokA", 64'(m_data_ok), 64'h1);
    chk("t5_rdA", 64'(m_rdata), 64'hA);
    cyc(2'b00, 1'b0, 1'b1, 32'hB);
    chk("t5_dokB", 64'(m_data_ok), 64'h2);
    chk("t5_rdB", 64'(m_rdata), 64'hB);
    cyc(2'b00, 1'b0, 1'b1, 32'hC);
    chk("t5_dokC", 64'(m_data_ok), 64'h1);
    chk("t5_rdC", 64'(m_rdata), 64'hC);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("t5_drain", 64'(outstanding), 64'd0);

    // Lock on master 1 while master 0 joins.
    cyc(2'b10, 1'b0, 1'b0, 32'h0);
    chk("t3_sreq", 64'(s_req), 64'd1);
    chk("t3_addr0", 64'(s_addr), 64'h1FC0_0010);
    chk("t3_aok0", 64'(m_addr_ok), 64'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(2'b11, 1'b0, 1'b0, 32'h0);
      chk("t3_lock", 64'(s_addr), 64'h1FC0_0010);
      chk("t3_aokw", 64'(m_addr_ok), 64'd0);
    end
    cyc(2'b11, 1'b1, 1'b0, 32'h0);
    chk("t3_acc1", 64'(m_addr_ok), 64'h2);
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("t3_acc0", 64'(m_addr_ok), 64'h1);
    chk("t3_addr", 64'(s_addr), 64'h1000);
    cyc(2'b00, 1'b0, 1'b1, 32'h11);
    chk("t3_out", 64'(outstanding), 64'd2);
    chk("t3_dok1", 64'(m_data_ok), 64'h2);
    cyc(2'b00, 1'b0, 1'b1, 32'h22);
    chk("t3_dok0", 64'(m_data_ok), 64'h1);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("t3_drain", 64'(outstanding), 64'd0);

    // Fill the FIFO, then a 5th request from master 1.
    for (int k = 0; k < 4; k++) begin
      cyc(2'b01, 1'b1, 1'b0, 32'h0);
      chk("t4_out", 64'(outstanding), 64'(k));
      chk("t4_aok", 64'(m_addr_ok), 64'h1);
    end
    cyc(2'b10, 1'b1, 1'b0, 32'h0);
    chk("t4_full_sreq", 64'(s_req), 64'd0);
    chk("t4_full_aok", 64'(m_addr_ok), 64'd0);
    chk("t4_full_out", 64'(outstanding), 64'd4);
    cyc(2'b10, 1'b1, 1'b1, 32'h33);
    chk("t4_pop_dok", 64'(m_data_ok), 64'h1);
    chk("t4_pop_sreq", 64'(s_req), 64'd0);
    chk("t4_pop_aok", 64'(m_addr_ok), 64'd0);
    cyc(2'b10, 1'b1, 1'b0, 32'h0);
    chk("t4_res_out", 64'(outstanding), 64'd3);
    chk("t4_res_aok", 64'(m_addr_ok), 64'h2);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b00, 1'b0, 1'b1, 32'h40 + k);
      if (k == 0) chk("t4_out4", 64'(outstanding), 64'd4);
      chk("t4_drain_dok", 64'(m_data_ok), (k < 3) ? 64'h1 : 64'h2);
    end
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("t4_drain", 64'(outstanding), 64'd0);
    chk("t4_err", 64'(err), 64'd0);

    // Locked master withdraws its request: no push.
    cyc(2'b01, 1'b0, 1'b0, 32'h0);
    chk("pv_sreq1", 64'(s_req), 64'd1);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("pv_sreq0", 64'(s_req), 64'd0);
    chk("pv_aok", 64'(m_addr_ok), 64'd0);
    cyc(2'b10, 1'b1, 1'b0, 32'h0);
    chk("pv_acc", 64'(m_addr_ok), 64'h2);
    cyc(2'b00, 1'b0, 1'b1, 32'h55);
    chk("pv_out", 64'(outstanding), 64'd1);
    chk("pv_dok", 64'(m_data_ok), 64'h2);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("pv_drain", 64'(outstanding), 64'd0);

    // Return with empty FIFO alongside an accept, then reset with 2 in flight.
    cyc(2'b01, 1'b1, 1'b1, 32'h44);
    chk("t6_aok", 64'(m_addr_ok), 64'h1);
    chk("t6_dok", 64'(m_data_ok), 64'd0);
    chk("t6_err0", 64'(err), 64'd0);
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("t6_err1", 64'(err), 64'd1);
    chk("t6_out1", 64'(outstanding), 64'd1);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("t6_sticky", 64'(err), 64'd1);
    chk("t6_out2", 64'(outstanding), 64'd2);
    @(negedge clk);
    rst = 1'b1; m_req = 2'b01; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    #2;
    chk("t6_rst_sreq", 64'(s_req), 64'd0);
    chk("t6_rst_aok", 64'(m_addr_ok), 64'd0);
    chk("t6_rst_dok", 64'(m_data_ok), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("t6_post_err", 64'(err), 64'd0);
    chk("t6_post_out", 64'(outstanding), 64'd0);
    chk("t6_post_aok", 64'(m_addr_ok), 64'd0);
    chk("t6_post_dok", 64'(m_data_ok), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
